// File: rtl/serial_wb_pkg.sv
// Shared command bytes, FSM states and helpers for the byte-serial wishbone link.
package serial_wb_pkg;

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ADDR,
        DATA,
        RESP,
        ACK
    } state_e;

    function automatic int addr_bytes(input int addr_bits);
        return (addr_bits + 7) / 8;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_wb_initiator.sv
// Wishbone pipelined slave -> byte-serial request frame on m_axis, reply rebuilt from s_axis.
// First request byte one cycle after acceptance; m_axis holds until tready; stall high until the cycle after ack.
module serial_wb_initiator
    import serial_wb_pkg::*;
#(
    parameter int ADDR_BITS      = 8,
    parameter int BYTES          = 1,
    parameter int SEL_WIDTH      = 1,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                   clk,
    input  logic                   sresetn,
    input  logic [ADDR_BITS-1:0]   s_wb_addr,
    input  logic [BYTES*8-1:0]     s_wb_dat_m2s,
    output logic [BYTES*8-1:0]     s_wb_dat_s2m,
    input  logic                   s_wb_we,
    input  logic [SEL_WIDTH-1:0]   s_wb_sel,
    input  logic                   s_wb_stb,
    input  logic                   s_wb_cyc,
    output logic                   s_wb_ack,
    output logic                   s_wb_stall,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [7:0]             m_axis_tdata,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tvalid,
    input  logic [7:0]             s_axis_tdata,
    output logic                   timeout
);

    localparam int ADDR_BYTES = addr_bytes(ADDR_BITS);
    localparam int DW         = BYTES * 8;
    localparam int AW_EXT     = ADDR_BYTES * 8;
    localparam int TX_W       = AW_EXT + DW;
    localparam int CNT_W      = $clog2(max2(ADDR_BYTES, BYTES) + 1);
    localparam int TO_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              we_q, we_d;
    logic [TX_W-1:0]   tx_sh_q, tx_sh_d;
    logic [DW-1:0]     rx_sh_q, rx_sh_d;
    logic              tvalid_q, tvalid_d;
    logic [7:0]        tdata_q, tdata_d;
    logic              rx_rdy_q, rx_rdy_d;
    logic              ack_q, ack_d;
    logic              stall_q, stall_d;
    logic [DW-1:0]     dat_q, dat_d;
    logic              to_q, to_d;

    logic              m_hs;
    logic              s_hs;
    logic [DW-1:0]     rx_next;
    logic [CNT_W-1:0]  rx_last;
    logic              sel_unused;

    assign m_hs       = tvalid_q && m_axis_tready;
    assign s_hs       = rx_rdy_q && s_axis_tvalid;
    assign rx_next    = DW'({rx_sh_q, s_axis_tdata});
    assign rx_last    = we_q ? '0 : DATA_LAST;
    assign sel_unused = ^s_wb_sel;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        to_cnt_d = to_cnt_q;
        we_d     = we_q;
        tx_sh_d  = tx_sh_q;
        rx_sh_d  = rx_sh_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        ack_d    = 1'b0;
        to_d     = 1'b0;
        dat_d    = '0;

        case (state_q)
            IDLE: begin
                if (s_wb_cyc && s_wb_stb && !stall_q) begin
                    we_d     = s_wb_we;
                    tx_sh_d  = {AW_EXT'(s_wb_addr), s_wb_dat_m2s};
                    tvalid_d = 1'b1;
                    tdata_d  = s_wb_we ? CMD_WRITE : CMD_READ;
                    cnt_d    = '0;
                    state_d  = HDR;
                end
            end
            HDR: begin
                if (m_hs) begin
                    tdata_d = tx_sh_q[TX_W-1 -: 8];
                    tx_sh_d = tx_sh_q << 8;
                    cnt_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (m_hs) begin
                    // Address and data share one serializer, so a write simply keeps shifting.
                    if (cnt_q != ADDR_LAST || we_q) begin
                        tdata_d = tx_sh_q[TX_W-1 -: 8];
                        tx_sh_d = tx_sh_q << 8;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d = '0;
                        if (we_q) begin
                            state_d = DATA;
                        end else begin
                            tvalid_d = 1'b0;
                            to_cnt_d = '0;
                            rx_sh_d  = '0;
                            state_d  = RESP;
                        end
                    end
                end
            end
            DATA: begin
                if (m_hs) begin
                    if (cnt_q == DATA_LAST) begin
                        tvalid_d = 1'b0;
                        cnt_d    = '0;
                        to_cnt_d = '0;
                        rx_sh_d  = '0;
                        state_d  = RESP;
                    end else begin
                        tdata_d = tx_sh_q[TX_W-1 -: 8];
                        tx_sh_d = tx_sh_q << 8;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            RESP: begin
                if (s_hs) begin
                    rx_sh_d  = rx_next;
                    to_cnt_d = '0;
                    if (cnt_q == rx_last) begin
                        ack_d   = 1'b1;
                        dat_d   = we_q ? '0 : rx_next;
                        state_d = ACK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TO_W'(1);
                    if (to_cnt_d == TO_LIMIT) begin
                        ack_d   = 1'b1;
                        to_d    = 1'b1;
                        dat_d   = '1;
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall and reply-ready follow the next state so both are clean registered outputs.
    assign stall_d  = (state_d != IDLE);
    assign rx_rdy_d = (state_d == RESP);

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            to_cnt_q <= '0;
            we_q     <= 1'b0;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            rx_rdy_q <= 1'b0;
            ack_q    <= 1'b0;
            stall_q  <= 1'b0;
            dat_q    <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            to_cnt_q <= to_cnt_d;
            we_q     <= we_d;
            tx_sh_q  <= tx_sh_d;
            rx_sh_q  <= rx_sh_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            rx_rdy_q <= rx_rdy_d;
            ack_q    <= ack_d;
            stall_q  <= stall_d;
            dat_q    <= dat_d;
            to_q     <= to_d;
        end
    end

    assign s_wb_dat_s2m  = dat_q;
    assign s_wb_ack      = ack_q;
    assign s_wb_stall    = stall_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign s_axis_tready = rx_rdy_q;
    assign timeout       = to_q;

endmodule

// File: tb/tb_serial_wb_initiator.sv
// Directed and randomized accesses against a frame/reply model of the serial wishbone initiator.
module tb_serial_wb_initiator;

    localparam int ABITS = 12;
    localparam int NB    = 2;
    localparam int AB    = 2;
    localparam int TOC   = 100;

    logic        clk = 1'b0;
    logic        sresetn;
    logic [11:0] s_wb_addr;
    logic [15:0] s_wb_dat_m2s;
    logic [15:0] s_wb_dat_s2m;
    logic        s_wb_we;
    logic [1:0]  s_wb_sel;
    logic        s_wb_stb;
    logic        s_wb_cyc;
    logic        s_wb_ack;
    logic        s_wb_stall;
    logic        m_axis_tready;
    logic        m_axis_tvalid;
    logic [7:0]  m_axis_tdata;
    logic        s_axis_tready;
    logic        s_axis_tvalid;
    logic [7:0]  s_axis_tdata;
    logic        timeout;

    serial_wb_initiator #(
        .ADDR_BITS     (ABITS),
        .BYTES         (NB),
        .SEL_WIDTH     (2),
        .TIMEOUT_CYCLES(TOC)
    ) dut (
        .clk          (clk),
        .sresetn      (sresetn),
        .s_wb_addr    (s_wb_addr),
        .s_wb_dat_m2s (s_wb_dat_m2s),
        .s_wb_dat_s2m (s_wb_dat_s2m),
        .s_wb_we      (s_wb_we),
        .s_wb_sel     (s_wb_sel),
        .s_wb_stb     (s_wb_stb),
        .s_wb_cyc     (s_wb_cyc),
        .s_wb_ack     (s_wb_ack),
        .s_wb_stall   (s_wb_stall),
        .m_axis_tready(m_axis_tready),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata (m_axis_tdata),
        .s_axis_tready(s_axis_tready),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata (s_axis_tdata),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  frame_q[$];
    logic [7:0]  exp_q[$];
    int          r_acc, r_first, r_last, r_resp0, r_ack_cyc, r_ack_cnt;
    int          r_stall_bad, r_unstable, r_early, r_to_bad;
    logic [15:0] r_rdata;
    logic        r_to, r_done, r_post_stall, r_post_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one access from a negedge; returns at the negedge after the ack (or after the budget).
    task automatic run_access(input logic we, input logic [11:0] addr, input logic [15:0] dat,
                              input int pct, input int nreply, input logic [7:0] rb0,
                              input logic [7:0] rb1, input bit hold);
        int         exp_len;
        int         rep_idx;
        bit         accepted, pv, pr, tr;
        logic [7:0] pd;
        exp_len = 1 + AB + (we ? NB : 0);
        frame_q.delete();
        r_acc = -1; r_first = -1; r_last = -1; r_resp0 = -1; r_ack_cyc = -1;
        r_ack_cnt = 0; r_stall_bad = 0; r_unstable = 0; r_early = 0; r_to_bad = 0;
        r_rdata = 16'h0; r_to = 1'b0; r_done = 1'b0;
        accepted = 1'b0; rep_idx = 0; pv = 1'b0; pr = 1'b0; pd = 8'h00;
        s_wb_we = we; s_wb_addr = addr; s_wb_dat_m2s = dat; s_wb_sel = 2'($urandom);
        for (int c = 0; c < 600 && !r_done; c++) begin
            if (accepted && !s_wb_stall) r_stall_bad++;
            if (timeout && !s_wb_ack) r_to_bad++;
            if (s_wb_ack) begin
                r_ack_cnt++; r_rdata = s_wb_dat_s2m; r_to = timeout; r_ack_cyc = c; r_done = 1'b1;
            end
            if (pv && !pr && (!m_axis_tvalid || m_axis_tdata !== pd)) r_unstable++;
            tr = (int'($urandom_range(99)) < pct);
            m_axis_tready = tr;
            if (m_axis_tvalid && tr) begin
                frame_q.push_back(m_axis_tdata);
                if (r_first < 0) r_first = c;
                r_last = c;
            end
            pv = m_axis_tvalid; pr = tr; pd = m_axis_tdata;
            if (s_axis_tready) begin
                if (r_resp0 < 0) r_resp0 = c;
                if (frame_q.size() < exp_len) r_early++;
            end
            s_axis_tvalid = (rep_idx < nreply);
            s_axis_tdata  = (rep_idx == 0) ? rb0 : rb1;
            if (s_axis_tvalid && s_axis_tready) rep_idx++;
            if (!accepted) begin
                s_wb_cyc = 1'b1; s_wb_stb = 1'b1;
                if (!s_wb_stall) begin accepted = 1'b1; r_acc = c; end
            end else if (!hold) begin
                s_wb_cyc = 1'b0; s_wb_stb = 1'b0;
            end
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        r_post_stall = s_wb_stall;
        r_post_ack   = s_wb_ack;
    endtask

    task automatic check_access(input string tag, input logic we, input logic [11:0] addr,
                                input logic [15:0] dat, input logic [7:0] rb0, input logic [7:0] rb1,
                                input bit expect_to);
        logic [15:0] exp_rd;
        int          n;
        exp_q.delete();
        exp_q.push_back(we ? 8'h57 : 8'h52);
        for (int i = AB - 1; i >= 0; i--) exp_q.push_back(8'((32'(addr) >> (8 * i)) & 32'hFF));
        if (we) for (int i = NB - 1; i >= 0; i--) exp_q.push_back(8'((32'(dat) >> (8 * i)) & 32'hFF));
        if (expect_to)  exp_rd = 16'hFFFF;
        else if (we)    exp_rd = 16'h0000;
        else            exp_rd = 16'((32'(rb0) * 256) + 32'(rb1));
        chk($sformatf("%s/done", tag), 32'(r_done), 32'd1);
        chk($sformatf("%s/len", tag), 32'(frame_q.size()), 32'(exp_q.size()));
        n = (frame_q.size() < exp_q.size()) ? frame_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s/byte%0d", tag, i), 32'(frame_q[i]), 32'(exp_q[i]));
        chk($sformatf("%s/rdata", tag), 32'(r_rdata), 32'(exp_rd));
        chk($sformatf("%s/ack_cnt", tag), 32'(r_ack_cnt), 32'd1);
        chk($sformatf("%s/timeout", tag), 32'(r_to), 32'(expect_to));
        chk($sformatf("%s/stall_hold", tag), 32'(r_stall_bad), 32'd0);
        chk($sformatf("%s/stall_rel", tag), 32'(r_post_stall), 32'd0);
        chk($sformatf("%s/ack_pulse", tag), 32'(r_post_ack), 32'd0);
        chk($sformatf("%s/unstable", tag), 32'(r_unstable), 32'd0);
        chk($sformatf("%s/early_rdy", tag), 32'(r_early), 32'd0);
        chk($sformatf("%s/to_alone", tag), 32'(r_to_bad), 32'd0);
    endtask

    initial begin
        logic        we;
        logic [11:0] addr;
        logic [15:0] dat;
        logic [7:0]  rb0, rb1;
        int          pct;

        sresetn = 1'b0;
        s_wb_addr = '0; s_wb_dat_m2s = '0; s_wb_we = 1'b0; s_wb_sel = '0;
        s_wb_stb = 1'b0; s_wb_cyc = 1'b0; m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        repeat (3) @(negedge clk);
        chk("rst/ack", 32'(s_wb_ack), 32'd0);
        chk("rst/stall", 32'(s_wb_stall), 32'd0);
        chk("rst/dat", 32'(s_wb_dat_s2m), 32'd0);
        chk("rst/tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst/tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst/s_tready", 32'(s_axis_tready), 32'd0);
        chk("rst/timeout", 32'(timeout), 32'd0);
        sresetn = 1'b1;
        @(negedge clk);

        run_access(1'b1, 12'h004, 16'h00A5, 100, 1, 8'h00, 8'h00, 1'b0);
        check_access("wr", 1'b1, 12'h004, 16'h00A5, 8'h00, 8'h00, 1'b0);
        chk("wr/first_lat", 32'(r_first), 32'(r_acc + 1));
        chk("wr/b2b", 32'(r_last - r_first), 32'(1 + AB + NB - 1));

        run_access(1'b0, 12'h081, 16'h0000, 100, 2, 8'h12, 8'h34, 1'b0);
        check_access("rd", 1'b0, 12'h081, 16'h0000, 8'h12, 8'h34, 1'b0);
        chk("rd/b2b", 32'(r_last - r_first), 32'(AB));

        run_access(1'b1, 12'h010, 16'h003C, 30, 1, 8'h5A, 8'h00, 1'b0);
        check_access("wr_bp", 1'b1, 12'h010, 16'h003C, 8'h5A, 8'h00, 1'b0);

        run_access(1'b0, 12'h155, 16'h0000, 100, 0, 8'h00, 8'h00, 1'b0);
        check_access("tmo", 1'b0, 12'h155, 16'h0000, 8'h00, 8'h00, 1'b1);
        chk("tmo/delay", 32'(r_ack_cyc - r_resp0), 32'(TOC));

        run_access(1'b0, 12'h3C3, 16'h0000, 100, 2, 8'hC0, 8'hDE, 1'b0);
        check_access("post_tmo", 1'b0, 12'h3C3, 16'h0000, 8'hC0, 8'hDE, 1'b0);

        run_access(1'b1, 12'h0F0, 16'hBEEF, 100, 1, 8'h77, 8'h00, 1'b1);
        check_access("hold1", 1'b1, 12'h0F0, 16'hBEEF, 8'h77, 8'h00, 1'b0);
        run_access(1'b1, 12'h0F0, 16'hBEEF, 100, 1, 8'h11, 8'h00, 1'b0);
        check_access("hold2", 1'b1, 12'h0F0, 16'hBEEF, 8'h11, 8'h00, 1'b0);
        chk("hold2/acc", 32'(r_acc), 32'd0);

        for (int k = 0; k < 8; k++) begin
            we   = 1'($urandom);
            addr = 12'($urandom);
            dat  = 16'($urandom);
            rb0  = 8'($urandom);
            rb1  = 8'($urandom);
            pct  = int'($urandom_range(100, 25));
            run_access(we, addr, dat, pct, we ? 1 : 2, rb0, rb1, 1'b0);
            check_access($sformatf("rnd%0d", k), we, addr, dat, rb0, rb1, 1'b0);
        end

        // Abort a write while the first address byte is stalled on the link.
        s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = 1'b1;
        s_wb_addr = 12'h2AB; s_wb_dat_m2s = 16'h1234; m_axis_tready = 1'b1;
        @(negedge clk);
        s_wb_cyc = 1'b0; s_wb_stb = 1'b0;
        @(negedge clk);
        m_axis_tready = 1'b0;
        @(negedge clk);
        chk("arst/pre_vld", 32'(m_axis_tvalid), 32'd1);
        chk("arst/pre_dat", 32'(m_axis_tdata), 32'h02);
        #2 sresetn = 1'b0;
        #1;
        chk("arst/vld", 32'(m_axis_tvalid), 32'd0);
        chk("arst/tdata", 32'(m_axis_tdata), 32'd0);
        chk("arst/stall", 32'(s_wb_stall), 32'd0);
        @(negedge clk);
        sresetn = 1'b1;
        @(negedge clk);
        run_access(1'b0, 12'h000, 16'h0000, 100, 2, 8'hAB, 8'hCD, 1'b0);
        check_access("arst_rd", 1'b0, 12'h000, 16'h0000, 8'hAB, 8'hCD, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_wb_initiator.md
Name: serial_wb_initiator

Overview:
Wishbone pipelined slave that turns each single access into a byte-serial request frame on an AXI-Stream output, then rebuilds the reply from an AXI-Stream input. It is the host-side counterpart of the serial wishbone master. An FPGA-resident controller, such as a soft core or a test sequencer, uses it to drive a remote wishbone bus over a UART pair.

Parameters:
ADDR_BITS, 8, wishbone address width; ADDR_BYTES = ceil(ADDR_BITS/8)
BYTES, 1, data width in bytes
SEL_WIDTH, 1, select width; accepted but not transmitted
TIMEOUT_CYCLES, 5000000, maximum cycles to wait for each reply byte; 0 disables the timeout

Ports:
clk  in  1  system clock
sresetn  in  1  reset, asynchronous, active-low
s_wb_addr  in  ADDR_BITS  access address
s_wb_dat_m2s  in  BYTES*8  write data
s_wb_dat_s2m  out  BYTES*8  read data, valid while s_wb_ack is high
s_wb_we  in  1  1 = write
s_wb_sel  in  SEL_WIDTH  ignored
s_wb_stb  in  1  strobe
s_wb_cyc  in  1  cycle
s_wb_ack  out  1  single-cycle completion pulse
s_wb_stall  out  1  high when a new request cannot be accepted
m_axis_tready  in  1  request stream ready
m_axis_tvalid  out  1  request stream valid
m_axis_tdata  out  8  request byte
s_axis_tready  out  1  reply stream ready
s_axis_tvalid  in  1  reply stream valid
s_axis_tdata  in  8  reply byte
timeout  out  1  one-cycle pulse when an access is aborted

Behaviour:
- Reset values: s_wb_ack=0, s_wb_stall=0, s_wb_dat_s2m=0, m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0, timeout=0, state=IDLE, all counters 0.
- Request acceptance: only in IDLE, when cyc&&stb and stall=0. On acceptance, latch addr, we and dat_m2s. stall goes high the next cycle and stays high until the cycle after ack/timeout.
- Request frame, in order:
  - header byte: 0x57 for a write, 0x52 for a read;
  - ADDR_BYTES address bytes, MSB first, address zero-extended;
  - for writes only, BYTES data bytes, MSB first.
- Reply frame:
  - read: BYTES data bytes, MSB first;
  - write: one byte of any value, which is discarded.
- States and transitions:
  - IDLE -> HDR on acceptance.
  - HDR -> ADDR when the header is handshaken.
  - ADDR: byte counter counts up to ADDR_BYTES-1. On the last handshake, go to DATA if a write, else to RESP.
  - DATA: counter counts up to BYTES-1, then go to RESP.
  - RESP: s_axis_tready=1. Each handshake shifts s_axis_tdata into a BYTES*8 shift register from the LSB end. After the last expected byte, go to ACK.
  - ACK: s_wb_ack=1 for exactly one cycle. s_wb_dat_s2m shows the assembled word (reads) or 0 (writes). Then go to IDLE.
- m_axis_tvalid is registered. Once raised, tvalid and tdata hold until tready; there is no retraction.
- Throughput: a new byte may follow in the next cycle after a handshake, giving back-to-back bytes when tready is held high.
- s_axis_tready is 0 outside RESP; reply bytes arriving early wait upstream.
- Timeout:
  - a counter clears on entry to RESP and on every reply handshake;
  - if it reaches TIMEOUT_CYCLES with the reply incomplete, pulse timeout and s_wb_ack together;
  - s_wb_dat_s2m is all-ones in that case, and the state returns to IDLE;
  - late bytes afterwards are left upstream, because tready=0 in IDLE.
- cyc dropping mid-transaction does not abort the frame. The frame completes, and the ack is issued even if cyc is low.
- Widths: byte counters are $clog2(max(ADDR_BYTES,BYTES)+1) bits. The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates.
- Reset asserted mid-frame returns every output to its reset value asynchronously; a partial frame may be left on the link.

Decomposition:
- Shared package serial_wb_pkg holds:
  - CMD_READ=8'h52 and CMD_WRITE=8'h57;
  - the state enum (IDLE, HDR, ADDR, DATA, RESP, ACK);
  - the function addr_bytes(ADDR_BITS).
- No sub-module is needed. The byte serializer is a shift register inside this module.

Test Plan:
- Write addr=0x04, data=0xA5, tready always 1 -> output bytes 0x57,0x04,0xA5 on consecutive cycles; after a reply byte 0x00, one ack with dat_s2m=0.
- Read addr=0x81 with BYTES=2, reply bytes 0x12,0x34 -> output bytes 0x52,0x81; ack with dat_s2m=0x1234; stall high from the cycle after acceptance until the cycle after ack.
- m_axis_tready randomly toggled, 30% duty, on a write of 0x3C to 0x10 -> each byte held stable until its handshake; frame content unchanged; no duplicated bytes.
- Read with TIMEOUT_CYCLES=100 and no reply -> timeout and ack pulse together 100 cycles after entering RESP; dat_s2m=0xFF; the next access is accepted normally.
- stb held high during a frame, followed by a second request -> the second request is not accepted until the cycle after ack; two distinct frames emitted.
- sresetn asserted during ADDR of a write -> tvalid falls immediately; after release, a read of 0x00 produces a clean 0x52,0x00 frame.
